wavelet_readout_sched: RTL

- Readout scheduler for the filterbank array of wavelet cores.
- On each sample strobe it snapshots every channel's 2-bit I and Q readout codes into a shadow buffer.
- It then drains enabled channels one beat at a time over a valid/ready stream toward the host-side capture logic.
- It tracks frames and flags frames dropped while a previous frame is still draining.

---
 rtl/wavelet_readout_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/wavelet_readout_sched.sv
// wavelet_readout_sched
//   Readout scheduler for the wavelet-core filterbank. On each accepted
//   sample strobe, it copies every channel's 2-bit I/Q readout codes and the
//   channel enable mask into a shadow buffer. It then walks the channels
//   once, presenting one beat per enabled channel on a valid/ready stream.
//   Strobes that arrive while a frame is still draining are dropped. Each
//   drop is counted and raises a sticky flag.
//
// Ports
//   clk_master  : master clock; all state updates on its rising edge
//   rst         : asynchronous, active-high reset
//   enable      : frame acceptance enable
//   frame_tick  : one-cycle sample strobe
//   ch_mask     : per-channel readout enable, latched at capture
//   read_out_I  : channel k I code at bits [2k+1:2k]
//   read_out_Q  : channel k Q code at bits [2k+1:2k]
//   out_valid   : beat available
//   out_ready   : consumer accepts the beat
//   out_ch      : channel index of the current beat
//   out_I/out_Q : snapshot codes of out_ch
//   out_last    : current beat is the last enabled channel of the frame
//   busy        : scheduler is in SCAN (doubles as the FSM state view)
//   frame_cnt   : accepted frames, wraps
//   drop_cnt    : dropped frames, saturates at all-ones
//   overflow    : sticky drop flag
//   clr_ovf     : clears overflow and drop_cnt (wins over a same-cycle drop)
//
// Stream handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high. out_valid is decoded from registers only and
// never depends on out_ready. While out_valid is high and out_ready is low,
// out_ch, out_I, out_Q and out_last hold their values.

module wavelet_readout_sched #(
  parameter int N_CH  = 16,
  parameter int CH_W  = 4,   // must equal $clog2(N_CH)
  parameter int CNT_W = 8
) (
  input  logic              clk_master,
  input  logic              rst,
  input  logic              enable,
  input  logic              frame_tick,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic [2*N_CH-1:0] read_out_I,
  input  logic [2*N_CH-1:0] read_out_Q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [1:0]        out_I,
  output logic [1:0]        out_Q,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_SCAN = 1'b1;
  localparam logic [CH_W-1:0]  PTR_MAX = CH_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Registered state
  logic [0:0]        state_q,     state_d;
  logic [CH_W-1:0]   ptr_q,       ptr_d;
  logic [2*N_CH-1:0] snap_i_q,    snap_i_d;
  logic [2*N_CH-1:0] snap_q_q,    snap_q_d;
  logic [N_CH-1:0]   mask_q,      mask_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q,  drop_cnt_d;
  logic              ovf_q,       ovf_d;

  // Decode
  logic              in_scan;
  logic              cur_en;
  logic [CH_W-1:0]   last_idx;
  logic [1:0]        cur_i;
  logic [1:0]        cur_q;
  logic              beat_valid;
  logic              beat_last;
  logic              beat_hs;
  logic              final_hs;
  logic              tick_en;
  logic              accept;
  logic              drop;
  logic              advance;

  assign in_scan = (state_q == ST_SCAN);
  assign cur_en  = mask_q[ptr_q];

  // Highest set bit of the captured mask marks the frame's final beat.
  // With an empty mask this stays 0, but no beat is ever valid then.
  always_comb begin
    last_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (mask_q[k]) last_idx = CH_W'(k);
    end
  end

  // Select the current channel's codes from the snapshot.
  always_comb begin
    cur_i = 2'b00;
    cur_q = 2'b00;
    for (int k = 0; k < N_CH; k++) begin
      if (ptr_q == CH_W'(k)) begin
        cur_i = snap_i_q[2*k +: 2];
        cur_q = snap_q_q[2*k +: 2];
      end
    end
  end

  assign beat_valid = in_scan & cur_en;
  assign beat_last  = beat_valid & (ptr_q == last_idx);
  assign beat_hs    = beat_valid & out_ready;
  assign final_hs   = beat_hs & beat_last;

  assign tick_en = frame_tick & enable;
  // A strobe on the final handshake restarts the scan with no idle bubble.
  assign accept  = tick_en & (~in_scan | final_hs);
  assign drop    = tick_en & in_scan & ~final_hs;
  // Disabled channels cost one cycle each. Enabled channels wait for the
  // handshake.
  assign advance = in_scan & (~cur_en | beat_hs);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    snap_i_d    = snap_i_q;
    snap_q_d    = snap_q_q;
    mask_d      = mask_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    ovf_d       = ovf_q;

    if (advance) begin
      if (ptr_q == PTR_MAX) begin
        state_d = ST_IDLE;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end

    // Capture overrides the end-of-scan transition to IDLE.
    if (accept) begin
      state_d     = ST_SCAN;
      ptr_d       = '0;
      snap_i_d    = read_out_I;
      snap_q_d    = read_out_Q;
      mask_d      = ch_mask;
      frame_cnt_d = frame_cnt_q + 1'b1;
    end

    if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      snap_i_q    <= '0;
      snap_q_q    <= '0;
      mask_q      <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      snap_i_q    <= snap_i_d;
      snap_q_q    <= snap_q_d;
      mask_q      <= mask_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = beat_valid;
  assign out_ch    = ptr_q;
  assign out_I     = cur_i;
  assign out_Q     = cur_q;
  assign out_last  = beat_last;
  assign busy      = in_scan;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = ovf_q;

endmodule
